// File: rtl/mem_respuesta.sv
// mem_respuesta: memory-side responder for the core's load/store port.
// Word-organised RAM with byte-lane extraction, sign/zero extension,
// read-modify-write for sub-word stores, alignment/range rejection and a
// programmable number of wait states ahead of the array access.
//
// Handshake: the requester raises valida with the request fields and holds
// them until it samples listo=1 at a rising edge. The request is taken at
// the first rising edge where valida=1 and the block is idle (ocupado=0);
// valida is ignored while ocupado=1. listo is a single-cycle pulse, and
// error_alin is only meaningful while listo=1.
module mem_respuesta #(
    parameter int PALABRAS = 1024,
    parameter int LATENCIA = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valida,
    input  logic        esc_mem,
    input  logic [31:0] dir,
    input  logic [2:0]  funct3,
    input  logic [31:0] dat_escritura,
    output logic [31:0] dat_lectura,
    output logic        listo,
    output logic        error_alin,
    output logic        ocupado,
    output logic [1:0]  estado_dbg
);

    localparam int AW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        ESPERA    = 2'd1,
        ACCESO    = 2'd2,
        RESPUESTA = 2'd3
    } estado_t;

    estado_t     r_estado;
    estado_t     w_sig;

    logic [31:0] r_dir;
    logic [2:0]  r_f3;
    logic        r_esc;
    logic [31:0] r_dat;
    logic [3:0]  r_cnt;
    logic [31:0] r_buf;
    logic [31:0] r_dat_lectura;

    logic [31:0] r_ram [PALABRAS];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_palabra;
    logic [7:0]    w_byte;
    logic [15:0]   w_media;
    logic [31:0]   w_carga;
    logic [31:0]   w_fusion;
    logic          w_rechazo;

    assign w_idx     = r_dir[AW+1:2];
    assign w_palabra = r_ram[w_idx];

    // Rejection is decided from the latched request, so it stays stable for the whole transaction
    always_comb begin
        w_rechazo = 1'b0;
        if ({2'b00, r_dir[31:2]} >= 32'(PALABRAS))          w_rechazo = 1'b1;
        if (r_f3 == 3'b011 || r_f3 == 3'b110 || r_f3 == 3'b111) w_rechazo = 1'b1;
        if (r_esc && r_f3[2])                                w_rechazo = 1'b1;
        if (r_f3[1:0] == 2'b01 && r_dir[0])                  w_rechazo = 1'b1;
        if (r_f3 == 3'b010 && r_dir[1:0] != 2'b00)           w_rechazo = 1'b1;
    end

    // Load path: pick the addressed lane/half from the word being read and extend it
    always_comb begin
        w_byte  = w_palabra[{r_dir[1:0], 3'b000} +: 8];
        w_media = r_dir[1] ? w_palabra[31:16] : w_palabra[15:0];
        case (r_f3)
            3'b000:  w_carga = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_carga = {24'h0, w_byte};
            3'b001:  w_carga = {{16{w_media[15]}}, w_media};
            3'b101:  w_carga = {16'h0, w_media};
            3'b010:  w_carga = w_palabra;
            default: w_carga = 32'h0;
        endcase
    end

    // Store path: merge store data into the word captured during ACCESO
    always_comb begin
        w_fusion = r_buf;
        case (r_f3)
            3'b000:  w_fusion[{r_dir[1:0], 3'b000} +: 8] = r_dat[7:0];
            3'b001:  w_fusion[{r_dir[1], 4'b0000} +: 16] = r_dat[15:0];
            default: w_fusion = r_dat;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_estado <= REPOSO;
        else        r_estado <= w_sig;
    end

    // Next-state logic: ESPERA lasts exactly LATENCIA cycles, skipped when LATENCIA is 0
    always_comb begin
        w_sig = r_estado;
        case (r_estado)
            REPOSO:    if (valida) w_sig = (LATENCIA > 0) ? ESPERA : ACCESO;
            ESPERA:    if (r_cnt == 4'd1) w_sig = ACCESO;
            ACCESO:    w_sig = RESPUESTA;
            RESPUESTA: w_sig = REPOSO;
            default:   w_sig = REPOSO;
        endcase
    end

    // Request latch, wait counter, read buffer and registered load result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir         <= 32'h0;
            r_f3          <= 3'b000;
            r_esc         <= 1'b0;
            r_dat         <= 32'h0;
            r_cnt         <= 4'd0;
            r_buf         <= 32'h0;
            r_dat_lectura <= 32'h0;
        end else begin
            case (r_estado)
                REPOSO: if (valida) begin
                    r_dir <= dir;
                    r_f3  <= funct3;
                    r_esc <= esc_mem;
                    r_dat <= dat_escritura;
                    r_cnt <= 4'(LATENCIA);
                end
                ESPERA: r_cnt <= r_cnt - 4'd1;
                ACCESO: begin
                    r_buf         <= w_palabra;
                    r_dat_lectura <= (w_rechazo || r_esc) ? 32'h0 : w_carga;
                end
                default: ;
            endcase
        end
    end

    // RAM write at the edge leaving RESPUESTA; an asserted reset cancels it
    always_ff @(posedge clk) begin
        if (reset && r_estado == RESPUESTA && r_esc && !w_rechazo)
            r_ram[w_idx] <= w_fusion;
    end

    // Outputs decoded from state so a reset clears them immediately
    always_comb begin
        listo       = (r_estado == RESPUESTA);
        error_alin  = (r_estado == RESPUESTA) && w_rechazo;
        ocupado     = (r_estado != REPOSO);
        dat_lectura = r_dat_lectura;
        estado_dbg  = r_estado;
    end

endmodule

// File: tb/tb_mem_respuesta.sv
// Bench for mem_respuesta: one instance with no wait states, one with three.
// A byte-addressed reference memory predicts each response; expectations are
// queued at issue and a per-instance monitor pops them when listo appears.
module tb_mem_respuesta;

  localparam int PAL = 64;

  logic        clk;
  logic        rst_n;
  logic        valida_v [2];
  logic        esc_v    [2];
  logic [31:0] dir_v    [2];
  logic [2:0]  f3_v     [2];
  logic [31:0] dat_w_v  [2];
  logic [31:0] dat_r_v  [2];
  logic        listo_v  [2];
  logic        err_v    [2];
  logic        ocu_v    [2];
  logic [1:0]  est_v    [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [7:0]  mem_m [2][4*PAL];

  int n_chk = 0;
  int n_pass = 0;

  mem_respuesta #(.PALABRAS(PAL), .LATENCIA(0)) u_lat0 (
    .clk(clk), .reset(rst_n), .valida(valida_v[0]), .esc_mem(esc_v[0]),
    .dir(dir_v[0]), .funct3(f3_v[0]), .dat_escritura(dat_w_v[0]),
    .dat_lectura(dat_r_v[0]), .listo(listo_v[0]), .error_alin(err_v[0]),
    .ocupado(ocu_v[0]), .estado_dbg(est_v[0])
  );

  mem_respuesta #(.PALABRAS(PAL), .LATENCIA(3)) u_lat3 (
    .clk(clk), .reset(rst_n), .valida(valida_v[1]), .esc_mem(esc_v[1]),
    .dir(dir_v[1]), .funct3(f3_v[1]), .dat_escritura(dat_w_v[1]),
    .dat_lectura(dat_r_v[1]), .listo(listo_v[1]), .error_alin(err_v[1]),
    .ocupado(ocu_v[1]), .estado_dbg(est_v[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference model
  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit rejected(input bit w, input logic [2:0] f3, input logic [31:0] a);
    if (a >= 32'(4*PAL)) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (w && f3 >= 3'd4) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [32:0] model_resp(input int k, input bit w, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v;
    int b;
    if (rejected(w, f3, a)) return {1'b1, 32'h0};
    if (w) return 33'h0;
    b = int'(a);
    case (f3)
      3'd0: v = {{24{mem_m[k][b][7]}}, mem_m[k][b]};
      3'd4: v = {24'h0, mem_m[k][b]};
      3'd1: v = {{16{mem_m[k][b+1][7]}}, mem_m[k][b+1], mem_m[k][b]};
      3'd5: v = {16'h0, mem_m[k][b+1], mem_m[k][b]};
      default: v = {mem_m[k][b+3], mem_m[k][b+2], mem_m[k][b+1], mem_m[k][b]};
    endcase
    return {1'b0, v};
  endfunction

  task automatic commit(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b;
    int n;
    b = int'(a);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mem_m[k][b+i] = d[8*i +: 8];
  endtask

  task automatic push_exp(input int k, input logic [32:0] e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic drop_exp(input int k);
    if (k == 0 && exp_q0.size() > 0) void'(exp_q0.pop_back());
    if (k == 1 && exp_q1.size() > 0) void'(exp_q1.pop_back());
  endtask

  task automatic wait_idle(input int k);
    @(negedge clk);
    for (int i = 0; i < 50 && ocu_v[k]; i++) @(negedge clk);
  endtask

  // driver: one full request, checking latency and busy time
  task automatic req(input int k, input bit w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input bit glitch, input bit use_exp,
                     input logic [32:0] exp_in);
    logic [32:0] e;
    int lat;
    int ocu;
    bit done;
    wait_idle(k);
    e = use_exp ? exp_in : model_resp(k, w, f3, a);
    push_exp(k, e);
    valida_v[k] = 1'b1; esc_v[k] = w; f3_v[k] = f3; dir_v[k] = a; dat_w_v[k] = d;
    @(posedge clk);
    lat = 0; ocu = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ocu_v[k]) ocu++;
      if (listo_v[k]) begin
        done = 1'b1;
        lat = i + 1;
        valida_v[k] = 1'b0;
      end else if (glitch) begin
        valida_v[k] = 1'($urandom_range(0, 1));
        dir_v[k] = $urandom;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL timeout k=%0d: no listo within 40 cycles, required %0d", k, lat_of(k) + 2);
      valida_v[k] = 1'b0;
      drop_exp(k);
    end else begin
      chk($sformatf("latency k=%0d", k), 32'(lat), 32'(lat_of(k) + 2));
      chk($sformatf("busy cycles k=%0d", k), 32'(ocu), 32'(lat_of(k) + 2));
      if (w && !rejected(w, f3, a)) commit(k, f3, a, d);
    end
  endtask

  // scoreboard monitors
  logic [32:0] e0, e1;
  always @(negedge clk) begin
    if (listo_v[0]) begin
      if (exp_q0.size() == 0) begin
        n_chk++;
        $display("FAIL lat0 unexpected listo: dat_lectura=%h error_alin=%b, no request pending",
                 dat_r_v[0], err_v[0]);
      end else begin
        e0 = exp_q0.pop_front();
        chk("lat0 dat_lectura", dat_r_v[0], e0[31:0]);
        chk("lat0 error_alin", {31'h0, err_v[0]}, {31'h0, e0[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (listo_v[1]) begin
      if (exp_q1.size() == 0) begin
        n_chk++;
        $display("FAIL lat3 unexpected listo: dat_lectura=%h error_alin=%b, no request pending",
                 dat_r_v[1], err_v[1]);
      end else begin
        e1 = exp_q1.pop_front();
        chk("lat3 dat_lectura", dat_r_v[1], e1[31:0]);
        chk("lat3 error_alin", {31'h0, err_v[1]}, {31'h0, e1[32]});
      end
    end
  end

  // stimulus
  logic [2:0]  rf3;
  logic [31:0] ra;
  bit          rw;
  int          sel;

  initial begin
    for (int k = 0; k < 2; k++) begin
      valida_v[k] = 1'b0; esc_v[k] = 1'b0; dir_v[k] = 32'h0; f3_v[k] = 3'd0; dat_w_v[k] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset listo", {31'h0, listo_v[k]}, 32'h0);
      chk("reset error_alin", {31'h0, err_v[k]}, 32'h0);
      chk("reset ocupado", {31'h0, ocu_v[k]}, 32'h0);
      chk("reset dat_lectura", dat_r_v[k], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // no wait states: word, byte and half accesses
    req(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, 33'h0);
    req(0, 0, 3'd2, 32'h10, 32'h0, 0, 1, {1'b0, 32'hDEADBEEF});
    req(0, 1, 3'd0, 32'h11, 32'h000000AA, 0, 0, 33'h0);
    req(0, 0, 3'd2, 32'h10, 32'h0, 0, 1, {1'b0, 32'hDEADAAEF});
    req(0, 0, 3'd0, 32'h11, 32'h0, 0, 1, {1'b0, 32'hFFFFFFAA});
    req(0, 0, 3'd4, 32'h11, 32'h0, 0, 1, {1'b0, 32'h000000AA});
    req(0, 1, 3'd1, 32'h12, 32'h00008001, 0, 0, 33'h0);
    req(0, 0, 3'd1, 32'h12, 32'h0, 0, 1, {1'b0, 32'hFFFF8001});
    req(0, 0, 3'd5, 32'h12, 32'h0, 0, 1, {1'b0, 32'h00008001});
    req(0, 0, 3'd2, 32'h10, 32'h0, 0, 1, {1'b0, 32'h8001AAEF});

    // rejections, then the word is still intact
    req(0, 0, 3'd2, 32'h12, 32'h0, 0, 1, {1'b1, 32'h0});
    req(0, 1, 3'd1, 32'h13, 32'h5555, 0, 1, {1'b1, 32'h0});
    req(0, 1, 3'd2, 32'(4*PAL), 32'h11223344, 0, 1, {1'b1, 32'h0});
    req(0, 1, 3'd4, 32'h14, 32'h77, 0, 1, {1'b1, 32'h0});
    req(0, 0, 3'd3, 32'h10, 32'h0, 0, 1, {1'b1, 32'h0});
    req(0, 0, 3'd2, 32'h10, 32'h0, 0, 1, {1'b0, 32'h8001AAEF});

    // random traffic over a fully initialised window
    for (int i = 0; i < 16; i++) req(0, 1, 3'd2, 32'(4*i), $urandom, 0, 0, 33'h0);
    for (int i = 0; i < 150; i++) begin
      rw  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      rf3 = (sel < 2) ? 3'd0 : (sel < 4) ? 3'd1 : (sel < 6) ? 3'd2 : (sel == 6) ? 3'd4 :
            (sel == 7) ? 3'd5 : 3'(3'd3 + 3'($urandom_range(0, 1)) * 3'd3);
      sel = $urandom_range(0, 9);
      ra  = (sel < 8) ? 32'($urandom_range(0, 63)) :
            (sel == 8) ? 32'(4*PAL + $urandom_range(0, 255)) : 32'hFFFFFFFC;
      req(0, rw, rf3, ra, $urandom, ($urandom_range(0, 3) == 0), 0, 33'h0);
    end

    // three wait states, request lines disturbed while busy
    req(1, 1, 3'd2, 32'h20, 32'h0, 0, 0, 33'h0);
    req(1, 1, 3'd2, 32'h24, 32'h0, 0, 0, 33'h0);
    req(1, 1, 3'd2, 32'h30, 32'hA5C3_5A3C, 1, 0, 33'h0);
    req(1, 0, 3'd2, 32'h30, 32'h0, 1, 1, {1'b0, 32'hA5C3_5A3C});

    // reset while waiting on a store: no response, no write
    wait_idle(1);
    valida_v[1] = 1'b1; esc_v[1] = 1'b1; f3_v[1] = 3'd2; dir_v[1] = 32'h20; dat_w_v[1] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk("abort precondition ocupado", {31'h0, ocu_v[1]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort listo", {31'h0, listo_v[1]}, 32'h0);
    chk("abort ocupado", {31'h0, ocu_v[1]}, 32'h0);
    chk("abort error_alin", {31'h0, err_v[1]}, 32'h0);
    chk("abort dat_lectura", dat_r_v[1], 32'h0);
    valida_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    req(1, 0, 3'd2, 32'h20, 32'h0, 0, 1, {1'b0, 32'h0});

    // reset during the response cycle of a store: still no write
    wait_idle(1);
    push_exp(1, 33'h0);
    valida_v[1] = 1'b1; esc_v[1] = 1'b1; f3_v[1] = 3'd2; dir_v[1] = 32'h24; dat_w_v[1] = 32'hCAFEF00D;
    @(posedge clk);
    for (int i = 0; i < 40 && !listo_v[1]; i++) @(negedge clk);
    valida_v[1] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("late abort ocupado", {31'h0, ocu_v[1]}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req(1, 0, 3'd2, 32'h24, 32'h0, 0, 1, {1'b0, 32'h0});
    req(1, 1, 3'd2, 32'h20, 32'h0, 0, 0, 33'h0);
    req(1, 0, 3'd2, 32'h20, 32'h0, 0, 1, {1'b0, 32'h0});

    repeat (5) @(negedge clk);
    chk("lat0 queue drained", 32'(exp_q0.size()), 32'h0);
    chk("lat3 queue drained", 32'(exp_q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_respuesta.md
Name: mem_respuesta

Overview:
- Data-memory responder: the memory-side end of the core's load/store port.
- The multicycle control unit presents an address, a write enable and store data during its memory phase. This block services the access against an internal word-organised RAM and signals completion.
- It handles LB/LH/LW/LBU/LHU and SB/SH/SW: byte-lane extraction, sign/zero extension, read-modify-write for sub-word stores, alignment/range checking, and a configurable wait-state latency.

Parameters:
- PALABRAS, 1024: RAM depth in 32-bit words. Valid byte addresses are 0 .. 4*PALABRAS-1.
- LATENCIA, 1: extra wait cycles before the array access. Range 0..15.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- valida, input, 1: request valid. Held by the requester until it samples listo.
- esc_mem, input, 1: 1 = store, 0 = load.
- dir, input, 32: byte address.
- funct3, input, 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dat_escritura, input, 32: store data, right-aligned.
- dat_lectura, output, 32: load result, extended.
- listo, output, 1: one-cycle completion pulse.
- error_alin, output, 1: asserted with listo when the request is rejected.
- ocupado, output, 1: high whenever the FSM is not in REPOSO.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to REPOSO.
  - listo=0, error_alin=0, ocupado=0, dat_lectura=0.
  - Latched request registers are cleared.
  - RAM contents are not reset; they are undefined until written.
- FSM states: REPOSO, ESPERA, ACCESO, RESPUESTA.
- REPOSO:
  - If valida=1 at a rising edge, latch dir, funct3, esc_mem and dat_escritura.
  - Load the wait counter with LATENCIA.
  - Go to ESPERA if LATENCIA>0, else go to ACCESO.
- ESPERA: decrement the counter each cycle; go to ACCESO when the counter reaches 1. The state lasts exactly LATENCIA cycles.
- ACCESO: synchronous read of word dir[31:2] into the internal buffer. Always go to RESPUESTA.
- RESPUESTA:
  - listo=1 for this single cycle.
  - Load: dat_lectura is updated, registered on entry to RESPUESTA.
  - Store: the merged word is written to the RAM at the edge leaving RESPUESTA, and dat_lectura is set to 0.
  - Next state is always REPOSO.
- Latency: with acceptance at edge E0, listo is high in the cycle after edge E0+LATENCIA+1. That is 2 cycles after acceptance for LATENCIA=0, and 3 cycles for LATENCIA=1.
- Back-to-back: the next request can be accepted at the second edge after listo. valida is ignored outside REPOSO.
- ocupado is 1 in ESPERA, ACCESO and RESPUESTA.
- Byte lanes are little-endian; lane = dir[1:0].
  - Load B/BU: the lane byte, sign- or zero-extended to 32 bits.
  - Load H/HU: bytes {dir[1],1} and {dir[1],0}, extended to 32 bits.
  - Load W: the whole word.
  - Store B: dat_escritura[7:0] replaces the lane byte; the other bytes are preserved from the ACCESO read.
  - Store H: dat_escritura[15:0] replaces half dir[1].
  - Store W: replaces the whole word.
- Rejection. A request is rejected if any of these hold:
  - H/HU with dir[0]=1;
  - W with dir[1:0]≠0;
  - funct3 ∈ {011,110,111};
  - a store with funct3[2]=1;
  - dir[31:2] ≥ PALABRAS.
- A rejected request:
  - still traverses the full state sequence with normal latency;
  - produces no RAM write;
  - sets dat_lectura=0, and sets error_alin=1 together with listo.
- dat_lectura holds its value between responses.
- error_alin is 0 on all non-rejected responses.
- Reset mid-operation: the request is abandoned, with no RAM write even if reset is asserted during RESPUESTA before the edge. listo is not generated.

Test Plan:
1. LATENCIA=0:
   - SW dir=0x10 dat=0xDEADBEEF, then LW 0x10.
   - Required: dat_lectura=0xDEADBEEF; each listo is 2 cycles after acceptance; error_alin=0.
2. SB dir=0x11 dat=0x000000AA, then:
   - LW 0x10 → 0xDEADAAEF.
   - LB 0x11 → 0xFFFFFFAA.
   - LBU 0x11 → 0x000000AA.
3. SH dir=0x12 dat=0x00008001, then:
   - LH 0x12 → 0xFFFF8001.
   - LHU 0x12 → 0x00008001.
   - LW 0x10 → 0x8001AAEF.
4. Rejections:
   - LW 0x12 → listo=1, error_alin=1, dat_lectura=0.
   - SH 0x13 and SW dir=4*PALABRAS → error_alin=1.
   - A following LW 0x10 still returns 0x8001AAEF.
5. LATENCIA=3:
   - Required: listo exactly 5 cycles after acceptance; ocupado high for 5 cycles.
   - Toggling valida and dir during ocupado changes nothing.
6. Reset during a store:
   - Drive reset=0 during ESPERA of SW 0x20 dat=0x12345678.
   - Required: outputs 0 immediately and no listo.
   - After reset: SW 0x20 dat=0x0 then LW 0x20 → 0x00000000; the aborted store did not write.
